// File: rtl/ppl_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// forwarding-select codes.
package ppl_haz_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } haz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WR  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/ppl_hazard_ctrl_if.sv
// Stage-register fields in, pipeline control out. The datapath side is the
// master, the controller is the slave. PPL_HAZ_PERF_EN adds perf counters.
interface ppl_hazard_ctrl_if;
  import ppl_haz_pkg::*;

  // Level signals only: no valid/ready handshake, every field is sampled
  // every cycle and every control output is valid in the same cycle.
  logic [4:0] id_rs, id_rt;
  logic       id_use_rs, id_use_rt;
  logic       id_jump, id_md_start, id_md_is_div, id_hilo_read, id_halt;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic       ex_regwrite, ex_memread, ex_branch_taken;
  logic [4:0] mem_rd;
  logic       mem_regwrite;
  logic [4:0] wr_rd;
  logic       wr_regwrite;

  logic       pc_write, ifid_write, ifid_flush, idex_flush;
  logic [1:0] fwd_a, fwd_b;
  logic       md_busy, halted;
  haz_state_e dbg_state;
`ifdef PPL_HAZ_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

`ifdef PPL_HAZ_PERF_EN
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_md_start,
           id_md_is_div, id_hilo_read, id_halt, ex_rs, ex_rt, ex_rd,
           ex_regwrite, ex_memread, ex_branch_taken, mem_rd, mem_regwrite,
           wr_rd, wr_regwrite,
    input  pc_write, ifid_write, ifid_flush, idex_flush, fwd_a, fwd_b,
           md_busy, halted, dbg_state, perf_stall_cnt, perf_flush_cnt
  );
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_md_start,
           id_md_is_div, id_hilo_read, id_halt, ex_rs, ex_rt, ex_rd,
           ex_regwrite, ex_memread, ex_branch_taken, mem_rd, mem_regwrite,
           wr_rd, wr_regwrite,
    output pc_write, ifid_write, ifid_flush, idex_flush, fwd_a, fwd_b,
           md_busy, halted, dbg_state, perf_stall_cnt, perf_flush_cnt
  );
`else
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_md_start,
           id_md_is_div, id_hilo_read, id_halt, ex_rs, ex_rt, ex_rd,
           ex_regwrite, ex_memread, ex_branch_taken, mem_rd, mem_regwrite,
           wr_rd, wr_regwrite,
    input  pc_write, ifid_write, ifid_flush, idex_flush, fwd_a, fwd_b,
           md_busy, halted, dbg_state
  );
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_md_start,
           id_md_is_div, id_hilo_read, id_halt, ex_rs, ex_rt, ex_rd,
           ex_regwrite, ex_memread, ex_branch_taken, mem_rd, mem_regwrite,
           wr_rd, wr_regwrite,
    output pc_write, ifid_write, ifid_flush, idex_flush, fwd_a, fwd_b,
           md_busy, halted, dbg_state
  );
`endif

endinterface

// File: rtl/ppl_fwd_unit.sv
// Combinational EX-operand forwarding select for one source register.
// The younger producer (MEM) takes priority over WR; $zero never forwards.
module ppl_fwd_unit
  import ppl_haz_pkg::*;
(
  input  logic [4:0] ex_src_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_regwrite_i,
  input  logic [4:0] wr_rd_i,
  input  logic       wr_regwrite_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (mem_regwrite_i && (mem_rd_i != 5'd0) && (mem_rd_i == ex_src_i)) begin
      fwd_o = FWD_MEM;
    end else if (wr_regwrite_i && (wr_rd_i != 5'd0) && (wr_rd_i == ex_src_i)) begin
      fwd_o = FWD_WR;
    end
  end

endmodule

// File: rtl/ppl_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipe: stalls, flushes,
// forwarding, HI/LO busy tracking and RUN/DRAIN/HALTED. Option: PPL_HAZ_PERF_EN.
module ppl_hazard_ctrl
  import ppl_haz_pkg::*;
#(
  parameter int MULT_LAT  = 4,
  parameter int DIV_LAT   = 12,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ppl_hazard_ctrl_if.slave     bus
);

  localparam logic [CNT_W-1:0] MULT_C  = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_C   = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] DRAIN_C = CNT_W'(DRAIN_CYC);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  haz_state_e       state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] drain_q, drain_d;

  logic luse, mdh, md_busy, stall, md_accept, jump_acc;
  logic pc_write, ifid_write, ifid_flush, idex_flush, halted;

  ppl_fwd_unit u_fwd_a (
    .ex_src_i       (bus.ex_rs),
    .mem_rd_i       (bus.mem_rd),
    .mem_regwrite_i (bus.mem_regwrite),
    .wr_rd_i        (bus.wr_rd),
    .wr_regwrite_i  (bus.wr_regwrite),
    .fwd_o          (bus.fwd_a)
  );

  ppl_fwd_unit u_fwd_b (
    .ex_src_i       (bus.ex_rt),
    .mem_rd_i       (bus.mem_rd),
    .mem_regwrite_i (bus.mem_regwrite),
    .wr_rd_i        (bus.wr_rd),
    .wr_regwrite_i  (bus.wr_regwrite),
    .fwd_o          (bus.fwd_b)
  );

  assign md_busy = (md_cnt_q != '0);
  assign luse = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                ((bus.id_use_rs && (bus.id_rs == bus.ex_rd)) ||
                 (bus.id_use_rt && (bus.id_rt == bus.ex_rd)));
  assign mdh  = md_busy && (bus.id_md_start || bus.id_hilo_read);

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    stall      = 1'b0;
    md_accept  = 1'b0;
    jump_acc   = 1'b0;
    case (state_q)
      RUN: begin
        stall = (luse || mdh) && !bus.ex_branch_taken;
        if (bus.ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (stall) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end else begin
          ifid_flush = bus.id_jump;
          jump_acc   = bus.id_jump;
          md_accept  = bus.id_md_start;
          if (bus.id_halt) begin
            state_d = DRAIN;
            drain_d = DRAIN_C;
          end
        end
      end
      DRAIN: begin
        if (bus.ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
        // Freeze only once both the bubbles and the HI/LO unit are done.
        if ((drain_q == ONE_C) && (md_cnt_q <= ONE_C)) begin
          state_d = HALTED;
          drain_d = '0;
        end else if (drain_q > ONE_C) begin
          drain_d = drain_q - ONE_C;
        end else begin
          drain_d = ONE_C;
        end
      end
      HALTED: begin
        halted     = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    md_cnt_d = '0;
    if (md_accept) begin
      md_cnt_d = bus.id_md_is_div ? DIV_C : MULT_C;
    end else if (md_busy) begin
      md_cnt_d = md_cnt_q - ONE_C;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      drain_q  <= drain_d;
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.ifid_write = ifid_write;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_flush = idex_flush;
  assign bus.md_busy    = md_busy;
  assign bus.halted     = halted;
  assign bus.dbg_state  = state_q;

`ifdef PPL_HAZ_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else if (state_q != HALTED) begin
      if (stall) perf_stall_q <= perf_stall_q + 32'd1;
      if (bus.ex_branch_taken || jump_acc) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = perf_stall_q;
  assign bus.perf_flush_cnt = perf_flush_q;
`else
  logic unused_jump_acc;
  assign unused_jump_acc = jump_acc;
`endif

endmodule

// File: tb/tb_ppl_hazard_ctrl.sv
// Directed + random bench for ppl_hazard_ctrl against a cycle-count model of
// the hazard rules (remaining-latency counters, mode name per cycle).
module tb_ppl_hazard_ctrl;
  import ppl_haz_pkg::*;

  localparam int MULT_LAT = 4, DIV_LAT = 12, DRAIN_CYC = 3;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ppl_hazard_ctrl_if bus();

  ppl_hazard_ctrl #(
    .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .DRAIN_CYC(DRAIN_CYC), .CNT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // model state: mode, cycles the HI/LO unit still owes, bubbles still owed
  int m_mode, m_md_left, m_drain_left;
  int n_mode, n_md_left, n_drain_left;
  logic e_pw, e_iw, e_iff, e_idf, e_busy, e_halted;
  logic [1:0] e_fa, e_fb;
  logic obs_pw;
`ifdef PPL_HAZ_PERF_EN
  logic [31:0] m_pstall, m_pflush, n_pstall, n_pflush;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_idle();
    bus.id_rs = 0; bus.id_rt = 0; bus.id_use_rs = 0; bus.id_use_rt = 0;
    bus.id_jump = 0; bus.id_md_start = 0; bus.id_md_is_div = 0;
    bus.id_hilo_read = 0; bus.id_halt = 0;
    bus.ex_rs = 0; bus.ex_rt = 0; bus.ex_rd = 0;
    bus.ex_regwrite = 0; bus.ex_memread = 0; bus.ex_branch_taken = 0;
    bus.mem_rd = 0; bus.mem_regwrite = 0; bus.wr_rd = 0; bus.wr_regwrite = 0;
  endtask

  task automatic drive_random();
    bus.id_rs = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
    bus.id_use_rs = ($urandom_range(0, 1) == 1); bus.id_use_rt = ($urandom_range(0, 1) == 1);
    bus.id_jump = ($urandom_range(0, 9) == 0);
    bus.id_md_start = ($urandom_range(0, 9) == 0);
    bus.id_md_is_div = ($urandom_range(0, 1) == 1);
    bus.id_hilo_read = ($urandom_range(0, 6) == 0);
    bus.id_halt = ($urandom_range(0, 39) == 0);
    bus.ex_rs = 5'($urandom_range(0, 3)); bus.ex_rt = 5'($urandom_range(0, 3));
    bus.ex_rd = 5'($urandom_range(0, 3));
    bus.ex_regwrite = ($urandom_range(0, 1) == 1);
    bus.ex_memread = ($urandom_range(0, 3) == 0);
    bus.ex_branch_taken = ($urandom_range(0, 9) == 0);
    bus.mem_rd = 5'($urandom_range(0, 3)); bus.mem_regwrite = ($urandom_range(0, 1) == 1);
    bus.wr_rd = 5'($urandom_range(0, 3)); bus.wr_regwrite = ($urandom_range(0, 1) == 1);
  endtask

  function automatic logic [1:0] fwd_of(input logic [4:0] src);
    if (bus.mem_regwrite && bus.mem_rd != 0 && bus.mem_rd == src) return 2'b10;
    if (bus.wr_regwrite && bus.wr_rd != 0 && bus.wr_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_mode = M_RUN; m_md_left = 0; m_drain_left = 0;
`ifdef PPL_HAZ_PERF_EN
    m_pstall = 0; m_pflush = 0;
`endif
  endtask

  // Expected outputs for this cycle and the model state after the next edge.
  task automatic model_eval();
    bit br, load_use, hilo_clash, stalled, go;
    br = bus.ex_branch_taken;
    load_use = bus.ex_memread && bus.ex_rd != 0 &&
               ((bus.id_use_rs && bus.id_rs == bus.ex_rd) ||
                (bus.id_use_rt && bus.id_rt == bus.ex_rd));
    hilo_clash = (m_md_left > 0) && (bus.id_md_start || bus.id_hilo_read);
    stalled = (m_mode == M_RUN) && (load_use || hilo_clash) && !br;
    go = (m_mode == M_RUN) && !stalled && !br;
    e_fa = fwd_of(bus.ex_rs);
    e_fb = fwd_of(bus.ex_rt);
    e_busy = (m_md_left > 0);
    e_halted = (m_mode == M_HALTED);
    if (m_mode == M_HALTED)      {e_pw, e_iw, e_iff, e_idf} = 4'b0011;
    else if (br)                 {e_pw, e_iw, e_iff, e_idf} = 4'b1111;
    else if (m_mode == M_DRAIN)  {e_pw, e_iw, e_iff, e_idf} = 4'b0001;
    else if (stalled)            {e_pw, e_iw, e_iff, e_idf} = 4'b0001;
    else                         {e_pw, e_iw, e_iff, e_idf} = {2'b11, bus.id_jump, 1'b0};

    n_mode = m_mode; n_drain_left = m_drain_left;
    if (go && bus.id_md_start) n_md_left = bus.id_md_is_div ? DIV_LAT : MULT_LAT;
    else n_md_left = (m_md_left > 0) ? m_md_left - 1 : 0;
    if (go && bus.id_halt) begin
      n_mode = M_DRAIN; n_drain_left = DRAIN_CYC;
    end else if (m_mode == M_DRAIN) begin
      if (m_drain_left == 1 && m_md_left <= 1) begin
        n_mode = M_HALTED; n_drain_left = 0;
      end else begin
        n_drain_left = (m_drain_left > 1) ? m_drain_left - 1 : 1;
      end
    end
`ifdef PPL_HAZ_PERF_EN
    n_pstall = m_pstall; n_pflush = m_pflush;
    if (m_mode != M_HALTED) begin
      if (stalled) n_pstall = m_pstall + 1;
      if (br || (go && bus.id_jump)) n_pflush = m_pflush + 1;
    end
`endif
  endtask

  task automatic check_all(input string tag);
    model_eval();
    check({tag, ".pc_write"},   32'(bus.pc_write),   32'(e_pw));
    check({tag, ".ifid_write"}, 32'(bus.ifid_write), 32'(e_iw));
    check({tag, ".ifid_flush"}, 32'(bus.ifid_flush), 32'(e_iff));
    check({tag, ".idex_flush"}, 32'(bus.idex_flush), 32'(e_idf));
    check({tag, ".fwd_a"},      32'(bus.fwd_a),      32'(e_fa));
    check({tag, ".fwd_b"},      32'(bus.fwd_b),      32'(e_fb));
    check({tag, ".md_busy"},    32'(bus.md_busy),    32'(e_busy));
    check({tag, ".halted"},     32'(bus.halted),     32'(e_halted));
    check({tag, ".state"},      32'(bus.dbg_state),  32'(m_mode));
`ifdef PPL_HAZ_PERF_EN
    check({tag, ".perf_stall"}, bus.perf_stall_cnt, m_pstall);
    check({tag, ".perf_flush"}, bus.perf_flush_cnt, m_pflush);
`endif
    obs_pw = bus.pc_write;
  endtask

  // Inputs already driven; check mid-cycle, then advance one clock.
  task automatic run_cycle(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    m_mode = n_mode; m_md_left = n_md_left; m_drain_left = n_drain_left;
`ifdef PPL_HAZ_PERF_EN
    m_pstall = n_pstall; m_pflush = n_pflush;
`endif
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    rst = 1'b1;
  endtask

  // Issue optional MD op, then halt next cycle; count DRAIN cycles to HALTED.
  task automatic halt_seq(input string tag, input bit with_md, input bit is_div, input int exp_drain);
    int n_drain;
    if (with_md) begin
      set_idle(); bus.id_md_start = 1; bus.id_md_is_div = is_div;
      run_cycle({tag, ".md"});
    end
    set_idle(); bus.id_halt = 1;
    run_cycle({tag, ".halt"});
    set_idle();
    n_drain = 0;
    for (int i = 0; i < 30 && bus.halted !== 1'b1; i++) begin
      if (bus.dbg_state == DRAIN) n_drain++;
      run_cycle({tag, ".drain"});
    end
    check({tag, ".drain_cycles"}, 32'(n_drain), 32'(exp_drain));
    check({tag, ".halted"}, 32'(bus.halted), 32'd1);
    run_cycle({tag, ".frozen"});
  endtask

  initial begin
    int n_stall, halted_run;
    set_idle();
    model_reset();
    #3;
    check_all("por");
    check("por.md_busy_const", 32'(bus.md_busy), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // load-use on rs, then same with ex_rd = $zero
    set_idle(); bus.ex_memread = 1; bus.ex_rd = 8; bus.id_rs = 8; bus.id_use_rs = 1;
    #1;
    check("luse.pc_write", 32'(bus.pc_write), 32'd0);
    check("luse.idex_flush", 32'(bus.idex_flush), 32'd1);
    run_cycle("luse");
    bus.ex_rd = 0; bus.id_rs = 0;
    #1;
    check("luse_r0.pc_write", 32'(bus.pc_write), 32'd1);
    run_cycle("luse_r0");

    // forwarding priority
    set_idle(); bus.ex_rs = 9; bus.mem_rd = 9; bus.wr_rd = 9;
    bus.mem_regwrite = 1; bus.wr_regwrite = 1;
    #1; check("fwd.mem", 32'(bus.fwd_a), 32'd2);
    run_cycle("fwd_mem");
    bus.mem_regwrite = 0;
    #1; check("fwd.wr", 32'(bus.fwd_a), 32'd1);
    run_cycle("fwd_wr");
    bus.ex_rs = 0;
    #1; check("fwd.rf", 32'(bus.fwd_a), 32'd0);
    run_cycle("fwd_rf");

    // DIV then MFLO: stalls exactly DIV_LAT cycles
    set_idle(); bus.id_md_start = 1; bus.id_md_is_div = 1;
    run_cycle("div");
    set_idle(); bus.id_hilo_read = 1;
    n_stall = 0;
    for (int i = 0; i < 20; i++) begin
      run_cycle("mflo");
      if (obs_pw == 1'b0) n_stall++;
      else break;
    end
    check("mflo.stall_cycles", 32'(n_stall), 32'(DIV_LAT));

    // branch beats load-use; MD start that cycle is dropped
    set_idle(); bus.ex_memread = 1; bus.ex_rd = 5; bus.id_rt = 5; bus.id_use_rt = 1;
    bus.ex_branch_taken = 1; bus.id_md_start = 1;
    #1;
    check("br.pc_write", 32'(bus.pc_write), 32'd1);
    check("br.ifid_flush", 32'(bus.ifid_flush), 32'd1);
    run_cycle("br");
    set_idle();
    #1; check("br.md_not_accepted", 32'(bus.md_busy), 32'd0);
    run_cycle("br_after");

    // jump with stall: stall wins
    set_idle(); bus.id_jump = 1; bus.ex_memread = 1; bus.ex_rd = 3; bus.id_rs = 3; bus.id_use_rs = 1;
    #1; check("jmp_stall.ifid_flush", 32'(bus.ifid_flush), 32'd0);
    run_cycle("jmp_stall");

    halt_seq("halt_plain", 1'b0, 1'b0, DRAIN_CYC);
    apply_reset();
    halt_seq("halt_mult", 1'b1, 1'b0, 3);
    apply_reset();
    halt_seq("halt_div", 1'b1, 1'b1, DIV_LAT - 1);
    apply_reset();

    // async reset in DRAIN while the HI/LO unit still has 5 cycles
    set_idle(); bus.id_md_start = 1; bus.id_md_is_div = 1;
    run_cycle("ar.div");
    set_idle(); bus.id_halt = 1;
    run_cycle("ar.halt");
    set_idle();
    for (int i = 0; i < 20 && !(m_mode == M_DRAIN && m_md_left == 5); i++) run_cycle("ar.wait");
    check("ar.reached", 32'(m_md_left), 32'd5);
    #2 rst = 1'b0;
    #1;
    check("ar.state", 32'(bus.dbg_state), 32'd0);
    check("ar.md_busy", 32'(bus.md_busy), 32'd0);
    check("ar.halted", 32'(bus.halted), 32'd0);
    model_reset();
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // random traffic
    halted_run = 0;
    for (int c = 0; c < 1500; c++) begin
      if (halted_run > 3 || $urandom_range(0, 199) == 0) begin
        apply_reset();
        halted_run = 0;
      end
      drive_random();
      run_cycle("rnd");
      halted_run = (m_mode == M_HALTED) ? halted_run + 1 : 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
